// File: rtl/bp_stall_histogram_reader.sv
// Stall-reason histogram: per-reason, instret and cycle counters read back via valid/ready + valid/yumi.
// Define BP_STALL_HIST_SATURATE_EN to make counters saturate instead of wrapping.
module bp_stall_histogram_reader #(
  parameter int num_reasons_p = 32,
  parameter int cnt_width_p   = 32,
  localparam int lg_reasons_lp = (num_reasons_p == 1) ? 1 : $clog2(num_reasons_p),
  localparam int addr_width_lp = ((num_reasons_p + 2) == 1) ? 1 : $clog2(num_reasons_p + 2)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     sample_v_i,
  input  logic                     instret_i,
  input  logic [lg_reasons_lp-1:0] reason_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  input  logic                     rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic                     rd_ready_o,
  output logic                     rd_v_o,
  output logic [cnt_width_p-1:0]   rd_data_o,
  input  logic                     rd_yumi_i
);

  localparam int num_cnt_lp = num_reasons_p + 2;

  typedef enum logic [1:0] {IDLE, RESP, CLEAR} state_e;

  state_e                   state_r, state_n;
  logic [cnt_width_p-1:0]   cnt_r [num_cnt_lp];
  logic [addr_width_lp-1:0] clr_idx_r;
  logic [cnt_width_p-1:0]   rd_data_r;
  logic [cnt_width_p-1:0]   rd_sel;
  logic                     count_en, rd_accept, clear_accept, clear_last;

  function automatic logic [cnt_width_p-1:0] bump(input logic [cnt_width_p-1:0] v);
`ifdef BP_STALL_HIST_SATURATE_EN
    return (&v) ? v : v + cnt_width_p'(1);
`else
    return v + cnt_width_p'(1);
`endif
  endfunction

  assign count_en     = (state_r != CLEAR) & en_i & sample_v_i;
  assign rd_ready_o   = (state_r == IDLE) & ~clear_i;
  assign rd_accept    = rd_v_i & rd_ready_o;
  assign clear_accept = (state_r == IDLE) & clear_i;
  assign clear_last   = (clr_idx_r == addr_width_lp'(num_cnt_lp - 1));
  assign busy_o       = (state_r == CLEAR);
  assign rd_v_o       = (state_r == RESP);
  assign rd_data_o    = rd_data_r;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:    if (clear_i) state_n = CLEAR;
               else if (rd_v_i) state_n = RESP;
      RESP:    if (rd_yumi_i) state_n = IDLE;
      CLEAR:   if (clear_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Out-of-range addresses fall through and return zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < num_cnt_lp; i++) begin
      if (rd_addr_i == addr_width_lp'(i)) rd_sel = cnt_r[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      clr_idx_r <= '0;
      rd_data_r <= '0;
    end else begin
      state_r <= state_n;
      if (clear_accept) clr_idx_r <= '0;
      else if (state_r == CLEAR) clr_idx_r <= clr_idx_r + addr_width_lp'(1);
      if (rd_accept) rd_data_r <= rd_sel;
    end
  end

  for (genvar g = 0; g < num_cnt_lp; g++) begin : g_cnt
    logic hit;
    if (g < num_reasons_p) begin : g_stall
      assign hit = count_en & ~instret_i & (reason_i == lg_reasons_lp'(g));
    end else if (g == num_reasons_p) begin : g_instret
      assign hit = count_en & instret_i;
    end else begin : g_cycle
      assign hit = count_en;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_r[g] <= '0;
      else if ((state_r == CLEAR) && (clr_idx_r == addr_width_lp'(g))) cnt_r[g] <= '0;
      else if (hit) cnt_r[g] <= bump(cnt_r[g]);
    end
  end

endmodule

// File: tb/tb_bp_stall_histogram_reader.sv
// Scoreboard bench for bp_stall_histogram_reader (24 reasons, 8-bit counters); honours BP_STALL_HIST_SATURATE_EN.
module tb_bp_stall_histogram_reader;

  localparam int N    = 24;
  localparam int W    = 8;
  localparam int NCNT = N + 2;

  logic         clk_i, reset_n_i;
  logic         en, sampleV, instret, clear, rdV, yumi;
  logic [4:0]   reason, rdAddr;
  logic         busy_o, rd_ready_o, rd_v_o;
  logic [W-1:0] rd_data_o;

  bp_stall_histogram_reader #(.num_reasons_p(N), .cnt_width_p(W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en), .sample_v_i(sampleV),
    .instret_i(instret), .reason_i(reason), .clear_i(clear), .busy_o(busy_o),
    .rd_v_i(rdV), .rd_addr_i(rdAddr), .rd_ready_o(rd_ready_o), .rd_v_o(rd_v_o),
    .rd_data_o(rd_data_o), .rd_yumi_i(yumi)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [W-1:0] modelCnt [NCNT];
  logic [W-1:0] expQ [$];
  bit           respPending;
  int           sweepLeft;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] modelInc(input logic [W-1:0] v);
`ifdef BP_STALL_HIST_SATURATE_EN
    return (v == 8'hFF) ? v : v + 8'd1;
`else
    return v + 8'd1;
`endif
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < NCNT; i++) modelCnt[i] = '0;
    expQ.delete();
    respPending = 0;
    sweepLeft   = 0;
  endfunction

  // Applies the rules for the inputs held across the edge that just happened.
  function automatic void updateModel();
    bit idle;
    bit wasResp;
    int wasSweep;
    idle     = !respPending && (sweepLeft == 0);
    wasResp  = respPending;
    wasSweep = sweepLeft;
    if (idle && !clear && rdV) begin
      expQ.push_back((int'(rdAddr) < NCNT) ? modelCnt[rdAddr] : '0);
      respPending = 1;
    end
    if ((sweepLeft == 0) && en && sampleV) begin
      modelCnt[N+1] = modelInc(modelCnt[N+1]);
      if (instret) modelCnt[N] = modelInc(modelCnt[N]);
      else if (int'(reason) < N) modelCnt[reason] = modelInc(modelCnt[reason]);
    end
    if (idle && clear) begin
      for (int i = 0; i < NCNT; i++) modelCnt[i] = '0;
      sweepLeft = NCNT;
    end
    if (wasResp && yumi) respPending = 0;
    if (wasSweep > 0) sweepLeft = sweepLeft - 1;
  endfunction

  task automatic checkOutput();
    check("rdValid", rd_v_o, respPending);
    check("busy", busy_o, sweepLeft > 0);
    check("rdReady", rd_ready_o, (!respPending && sweepLeft == 0 && !clear));
  endtask

  // Entered and left at posedge+1.
  task automatic applyStimulus(input bit e, input bit s, input bit ins, input logic [4:0] rsn,
                               input bit clr, input bit rv, input logic [4:0] ad, input bit y);
    en = e; sampleV = s; instret = ins; reason = rsn;
    clear = clr; rdV = rv; rdAddr = ad; yumi = y;
    #1 checkOutput();
    @(posedge clk_i);
    updateModel();
    #1;
  endtask

  task automatic idleInputs();
    en = 0; sampleV = 0; instret = 0; reason = '0; clear = 0; rdV = 0; rdAddr = '0; yumi = 0;
  endtask

  task automatic doReset();
    idleInputs();
    reset_n_i = 0;
    #1;
    check("rstBusy", busy_o, 0);
    check("rstRdValid", rd_v_o, 0);
    check("rstRdReady", rd_ready_o, 1);
    resetModel();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_n_i = 1;
  endtask

  task automatic readAddr(input logic [4:0] a);
    applyStimulus(0, 0, 0, 0, 0, 1, a, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk_i) begin
    if (reset_n_i && rd_v_o) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL rdUnexpected: got response %0d expected none at %0t", rd_data_o, $time);
      end else begin
        check("rdData", rd_data_o, expQ[0]);
        if (yumi) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int busyLen;
    reset_n_i = 0;
    idleInputs();
    resetModel();
    @(posedge clk_i);
    #1 doReset();

    // Basic histogram: 3,3,5 stalls then 7 retirements.
    applyStimulus(1, 1, 0, 3, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 3, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 5, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    readAddr(3); readAddr(5); readAddr(N); readAddr(N + 1);

    // Frozen samples, then an out-of-range reason code.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 7, 0, 0, 0, 0);
    readAddr(N + 1);
    applyStimulus(1, 1, 0, 28, 0, 0, 0, 0);
    readAddr(N + 1);
    for (int a = 0; a < 32; a++) readAddr(a[4:0]);

    // Read racing an increment of the same counter, then a held response.
    applyStimulus(1, 1, 0, 3, 0, 1, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 3, 0, 1, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Clear wins over a simultaneous read; samples in the sweep are dropped.
    applyStimulus(1, 1, 0, 2, 1, 1, 3, 0);
    busyLen = 0;
    for (int i = 0; i < 100 && sweepLeft > 0; i++) begin
      if (busy_o) busyLen++;
      applyStimulus(1, 1, i[0], 4, 0, 0, 0, 0);
    end
    check("clearBusyLen", busyLen, NCNT);
    for (int a = 0; a < NCNT; a++) readAddr(a[4:0]);

    // Overflow behaviour of a stall counter.
    doReset();
    for (int i = 0; i < 255; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    readAddr(0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    readAddr(0);
    readAddr(N + 1);

    // Asynchronous reset mid-sweep and mid-response.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
    #2 doReset();
    readAddr(N + 1);
    applyStimulus(1, 1, 0, 9, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 9, 0);
    #2 doReset();
    readAddr(N + 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
                    5'($urandom % 32), ($urandom % 64) == 0, ($urandom % 2) == 1,
                    5'($urandom % 32), ($urandom % 2) == 1);
    end

    for (int i = 0; i < 60 && (respPending || sweepLeft > 0); i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    check("queueDrained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
